// File: rtl/gf571_pkg.sv
// Shared definitions for the GF(2^571) reduction datapath,
// field polynomial f(x) = x^571 + x^10 + x^5 + x^2 + 1.
package gf571_pkg;

  localparam int GF_M     = 571;
  localparam int PROD_W   = 1141;
  localparam int NUM_TAPS = 4;

  // x^571 == x^10 + x^5 + x^2 + 1, so a folded bit lands at these offsets
  localparam logic [NUM_TAPS-1:0][3:0] TAPS = {4'd10, 4'd5, 4'd2, 4'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [GF_M-1:0]   gf_elem_t;
  typedef logic [PROD_W-1:0] gf_prod_t;

  function automatic int num_folds(input int chunk);
    return (GF_M - 1 + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/gf571_fold_step.sv
// Combinational fold of one CHUNK-wide slice of the excess degree,
// selected by the fold counter, into the lower bits of the accumulator.
module gf571_fold_step
  import gf571_pkg::*;
#(
  parameter int CHUNK = 64,
  parameter int CNT_W = 4
) (
  input  gf_prod_t         acc_i,
  input  logic [CNT_W-1:0] cnt_i,
  output gf_prod_t         acc_o
);

  logic [10:0] hi_s;
  logic [10:0] lo_raw_s;
  logic [10:0] lo_s;
  logic        sel_s;

  // slice bounds: hi = 1140 - cnt*CHUNK, lo clamped at the field degree
  always_comb begin
    hi_s     = 11'(PROD_W - 1 - int'(cnt_i) * CHUNK);
    lo_raw_s = hi_s - 11'(CHUNK - 1);
    lo_s     = (lo_raw_s < 11'(GF_M)) ? 11'(GF_M) : lo_raw_s;
  end

  // Targets always sit strictly below lo, so reading acc_i for the source bit is safe
  always_comb begin
    acc_o = acc_i;
    sel_s = 1'b0;
    for (int j = GF_M; j < PROD_W; j++) begin
      sel_s    = (11'(j) >= lo_s) && (11'(j) <= hi_s);
      acc_o[j] = acc_o[j] & ~sel_s;
      for (int t = 0; t < NUM_TAPS; t++) begin
        acc_o[j - GF_M + int'(TAPS[t])] = acc_o[j - GF_M + int'(TAPS[t])] ^ (acc_i[j] & sel_s);
      end
    end
  end

endmodule

// File: rtl/gf571_reduce_seq.sv
// Sequential GF(2^571) reducer: accepts an 1141-bit product, folds the
// excess degree CHUNK bits per cycle top-down, returns the 571-bit element.
module gf571_reduce_seq
  import gf571_pkg::*;
#(
  parameter int CHUNK = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PROD_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [GF_M-1:0]     out_data,
  output logic                busy
);

  localparam int NUM_FOLDS = num_folds(CHUNK);
  localparam int CNT_W     = $clog2(NUM_FOLDS + 1);

  if ((CHUNK < 11) || (CHUNK > 285)) begin : g_bad_chunk
    $error("gf571_reduce_seq: CHUNK must lie in 11..285");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gf_prod_t         acc_q, acc_d;
  gf_prod_t         fold_s;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  gf571_fold_step #(
    .CHUNK (CHUNK),
    .CNT_W (CNT_W)
  ) u_fold (
    .acc_i (acc_q),
    .cnt_i (cnt_q),
    .acc_o (fold_s)
  );

  // next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d   = in_data;
          cnt_d   = '0;
          state_d = FOLD;
        end else begin
          state_d = IDLE;
        end
      end
      FOLD: begin
        acc_d = fold_s;
        if (cnt_q == CNT_W'(NUM_FOLDS - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q[GF_M-1:0];

endmodule

// File: tb/tb_gf571_reduce_seq.sv
// Directed and reference-model checks for gf571_reduce_seq at CHUNK=64,
// plus CHUNK=11 and CHUNK=285 instances fed the same random products.
module tb_gf571_reduce_seq;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           out_ready;
  logic           in_valid_x;
  logic           out_ready_x;
  logic [1140:0]  in_data;
  logic           in_ready, out_valid, busy;
  logic [570:0]   out_data;
  logic           in_ready_11, out_valid_11, busy_11;
  logic [570:0]   out_data_11;
  logic           in_ready_285, out_valid_285, busy_285;
  logic [570:0]   out_data_285;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf571_reduce_seq #(.CHUNK(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  gf571_reduce_seq #(.CHUNK(11)) dut11 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready_11),
    .in_data(in_data), .out_valid(out_valid_11), .out_ready(out_ready_x),
    .out_data(out_data_11), .busy(busy_11)
  );

  gf571_reduce_seq #(.CHUNK(285)) dut285 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready_285),
    .in_data(in_data), .out_valid(out_valid_285), .out_ready(out_ready_x),
    .out_data(out_data_285), .busy(busy_285)
  );

  function automatic logic [1140:0] polymul(input logic [570:0] a, input logic [570:0] b);
    logic [1140:0] r;
    r = '0;
    for (int i = 0; i < 571; i++) begin
      if (b[i]) r = r ^ ({570'd0, a} << i);
    end
    return r;
  endfunction

  // bit-serial reference: clear the top bit, add x^(i-571) * (x^10+x^5+x^2+1)
  function automatic logic [570:0] ref_reduce(input logic [1140:0] c_in);
    logic [1140:0] c;
    c = c_in;
    for (int i = 1140; i >= 571; i--) begin
      if (c[i]) begin
        c[i]       = 1'b0;
        c[i - 571] = c[i - 571] ^ 1'b1;
        c[i - 569] = c[i - 569] ^ 1'b1;
        c[i - 566] = c[i - 566] ^ 1'b1;
        c[i - 561] = c[i - 561] ^ 1'b1;
      end
    end
    return c[570:0];
  endfunction

  function automatic logic [570:0] rand_elem();
    logic [575:0] v;
    for (int w = 0; w < 18; w++) v[w*32 +: 32] = $urandom;
    return v[570:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat counts edges after the accept edge until out_valid is seen
  task automatic run_one(input logic [1140:0] p, output logic [570:0] r, output int lat);
    int guard;
    guard    = 0;
    in_data  = p;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_timeout: out_valid=%b required 1", out_valid);
    end
    r = out_data;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid_x = 1'b0;
    out_ready = 1'b1; out_ready_x = 1'b1; in_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== 571'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
  endtask

  task automatic test_top_bit();
    logic [1140:0] p;
    logic [570:0]  e, r;
    int lat;
    p = '0; p[1140] = 1'b1;
    e = '0; e[569] = 1'b1; e[18] = 1'b1; e[3] = 1'b1; e[2] = 1'b1; e[0] = 1'b1;
    run_one(p, r, lat);
    checks++; if (r !== e) begin errors++; $display("FAIL top_bit: got %h want %h", r, e); end
    // nine fold edges after accept: the tenth cycle counting the accept cycle
    checks++; if (lat !== 9) begin errors++; $display("FAIL latency: got %0d want 9", lat); end
  endtask

  task automatic test_bit571();
    logic [1140:0] p;
    logic [570:0]  r;
    int lat;
    p = '0; p[571] = 1'b1;
    run_one(p, r, lat);
    checks++; if (r !== 571'h425) begin errors++; $display("FAIL bit571: got %h want 425", r); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bit571_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_low_passthrough();
    logic [570:0] lo, r;
    int lat;
    for (int k = 0; k < 3; k++) begin
      lo = rand_elem();
      run_one({570'd0, lo}, r, lat);
      checks++; if (r !== lo) begin errors++; $display("FAIL passthrough_%0d: got %h want %h", k, r, lo); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    in_data = '0; in_data[571] = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    for (int i = 0; i < 20; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d: got %b want 1", i, out_valid); end
      checks++; if (out_data !== 571'h425) begin errors++; $display("FAIL bp_out_data_%0d: got %h want 425", i, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_fold();
    logic [1140:0] p;
    logic [570:0]  e, r;
    int lat;
    in_data = '0; in_data[1000] = 1'b1; in_data[3] = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (out_data !== 571'd0) begin errors++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
    p = '0; p[1140] = 1'b1;
    e = '0; e[569] = 1'b1; e[18] = 1'b1; e[3] = 1'b1; e[2] = 1'b1; e[0] = 1'b1;
    run_one(p, r, lat);
    checks++; if (r !== e) begin errors++; $display("FAIL midrst_after: got %h want %h", r, e); end
  endtask

  task automatic test_back_to_back();
    logic [1140:0] p [3];
    logic [570:0]  e [3];
    logic [570:0]  got [3];
    int acc_cyc [3];
    int n_acc, n_out, cyc;
    logic acc_now;
    p[0] = '0; p[0][1140] = 1'b1;
    p[1] = '0; p[1][571] = 1'b1;
    p[2] = {570'd0, rand_elem()};
    e[0] = '0; e[0][569] = 1'b1; e[0][18] = 1'b1; e[0][3] = 1'b1; e[0][2] = 1'b1; e[0][0] = 1'b1;
    e[1] = 571'h425;
    e[2] = p[2][570:0];
    n_acc = 0; n_out = 0; cyc = 0;
    out_ready = 1'b1;
    in_data = p[0];
    in_valid = 1'b1;
    while (n_out < 3 && cyc < 300) begin
      acc_now = in_ready && in_valid;
      if (out_valid && n_out < 3) begin
        got[n_out] = out_data;
        n_out++;
      end
      step();
      cyc++;
      if (acc_now && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) in_data = p[n_acc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (n_out !== 3 || n_acc !== 3) begin errors++; $display("FAIL b2b_count: got acc=%0d out=%0d want 3/3", n_acc, n_out); end
    if (n_acc == 3) begin
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 11) begin errors++; $display("FAIL b2b_spacing_01: got %0d want 11", acc_cyc[1] - acc_cyc[0]); end
      checks++; if (acc_cyc[2] - acc_cyc[1] !== 11) begin errors++; $display("FAIL b2b_spacing_12: got %0d want 11", acc_cyc[2] - acc_cyc[1]); end
    end
    for (int k = 0; k < 3; k++) begin
      if (k < n_out) begin
        checks++; if (got[k] !== e[k]) begin errors++; $display("FAIL b2b_data_%0d: got %h want %h", k, got[k], e[k]); end
      end
    end
    step();
  endtask

  task automatic test_random_products();
    logic [570:0]  a, b, e, r0, r1, r2;
    logic [1140:0] c;
    logic g0, g1, g2;
    out_ready = 1'b1; out_ready_x = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a = rand_elem();
      b = rand_elem();
      c = polymul(a, b);
      e = ref_reduce(c);
      in_data = c;
      in_valid = 1'b1; in_valid_x = 1'b1;
      step();
      in_valid = 1'b0; in_valid_x = 1'b0;
      g0 = 1'b0; g1 = 1'b0; g2 = 1'b0;
      r0 = '0; r1 = '0; r2 = '0;
      for (int n = 0; n < 200 && !(g0 && g1 && g2); n++) begin
        if (out_valid && !g0)     begin r0 = out_data;     g0 = 1'b1; end
        if (out_valid_11 && !g1)  begin r1 = out_data_11;  g1 = 1'b1; end
        if (out_valid_285 && !g2) begin r2 = out_data_285; g2 = 1'b1; end
        step();
      end
      checks++; if (!g0 || r0 !== e) begin errors++; $display("FAIL rand64_%0d: got %h want %h", k, r0, e); end
      checks++; if (!g1 || r1 !== e) begin errors++; $display("FAIL rand11_%0d: got %h want %h", k, r1, e); end
      checks++; if (!g2 || r2 !== e) begin errors++; $display("FAIL rand285_%0d: got %h want %h", k, r2, e); end
    end
  endtask

  initial begin
    test_reset();
    test_top_bit();
    test_bit571();
    test_low_passthrough();
    test_backpressure();
    test_reset_mid_fold();
    test_back_to_back();
    test_random_products();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
